mem_responder: RTL and testbench

Memory-side responder for the pipelined core's instruction and data ports. It serves one instruction read and one data read or write per cycle from a shared dual-port word RAM. Both ports have one-cycle synchronous read latency, matching the core's fetch and writeback timing. It also decodes a small MMIO window holding a console output FIFO and a free-running cycle counter. It sits between the core and the board top level.

---
 rtl/mem_pkg.sv | 19 +
 rtl/con_fifo.sv | 59 +++++
 rtl/mem_responder.sv | 168 ++++++++++++++++
 tb/tb_mem_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the memory responder: MMIO register map, console
// status bit layout and the default MMIO window base.
package mem_pkg;

    // Default byte base of the 256-byte MMIO window
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;

    // MMIO register offsets within the window (byte offset addr[7:0])
    localparam logic [7:0] CON_DATA_OFS   = 8'h00;
    localparam logic [7:0] CON_STATUS_OFS = 8'h04;
    localparam logic [7:0] CYCLE_OFS      = 8'h08;

    // CON_STATUS bit positions
    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_OVF_BIT   = 2;
    localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/con_fifo.sv
// Synchronous FIFO for console output bytes. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate flag.
// A push into a full FIFO is still taken when a pop happens on the same
// edge, because the slot being written is the one the pop frees.
// The head is forced to zero while empty so the sink never sees stale data.
module con_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer update with synchronous active-low reset discarding contents
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the core: a dual-port word RAM serving one
// instruction fetch and one data load/store per cycle, both with one-cycle
// registered read latency, plus an MMIO window holding a console FIFO and a
// free-running cycle counter. Only the data port decodes MMIO.
module mem_responder
    import mem_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter string       INIT_FILE = "",
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
    parameter int          CON_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_mem_r_addr,
    output logic [31:0] i_mem_r_data,
    input  logic [31:0] d_mem_w_addr,
    input  logic [31:0] d_mem_w_data,
    input  logic [31:0] d_mem_we,
    input  logic [31:0] d_mem_oe,
    output logic [31:0] d_mem_r_data,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready
);

    localparam int CNT_W = $clog2(CON_DEPTH) + 1;

    logic [31:0]       ram [0:(2**ADDR_W)-1];

    logic [ADDR_W-1:0] i_idx;
    logic [ADDR_W-1:0] d_idx;
    logic              we;
    logic              oe;
    logic              mmio_hit;
    logic [7:0]        mmio_ofs;
    logic              ram_we;

    logic              con_push;
    logic              con_pop;
    logic              con_full;
    logic              con_empty;
    logic [CNT_W-1:0]  con_count;

    logic              overflow;
    logic              ovf_set;
    logic              status_rd;
    logic [31:0]       status_word;

    logic [31:0]       cycle_cnt;
    logic [31:0]       cycle_next;
    logic              cyc_wr;

    logic [31:0]       mmio_rdata;

    // Only the low control bits and the decoded address/data fields matter;
    // the rest of these buses is intentionally ignored.
    logic              unused_ok;
    assign unused_ok = &{1'b0, i_mem_r_addr, d_mem_w_data, d_mem_we, d_mem_oe};

    // Word index drops the byte offset and any bits above the RAM size,
    // so addresses outside the MMIO window alias onto the RAM.
    assign i_idx    = i_mem_r_addr[ADDR_W+1:2];
    assign d_idx    = d_mem_w_addr[ADDR_W+1:2];
    assign we       = d_mem_we[0];
    assign oe       = d_mem_oe[0];
    assign mmio_hit = (d_mem_w_addr[31:8] == MMIO_BASE[31:8]);
    assign mmio_ofs = d_mem_w_addr[7:0];

    // Stores in the reset cycle and stores into the MMIO window never reach RAM
    assign ram_we    = rst && we && !mmio_hit;

    assign con_push  = we && mmio_hit && (mmio_ofs == CON_DATA_OFS);
    assign con_pop   = con_valid && con_ready;
    assign con_valid = !con_empty;
    assign cyc_wr    = we && mmio_hit && (mmio_ofs == CYCLE_OFS);
    assign status_rd = oe && mmio_hit && (mmio_ofs == CON_STATUS_OFS);
    assign ovf_set   = con_push && con_full && !con_pop;

    con_fifo #(
        .DEPTH (CON_DEPTH),
        .WIDTH (8)
    ) u_con_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (con_push),
        .pop   (con_pop),
        .wdata (d_mem_w_data[7:0]),
        .rdata (con_data),
        .full  (con_full),
        .empty (con_empty),
        .count (con_count)
    );

    // RAM write port; read ports below sample the pre-write word (read-first)
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[d_idx] <= d_mem_w_data;
        end
    end

    // Instruction fetch port: registered read every cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            i_mem_r_data <= '0;
        end else begin
            i_mem_r_data <= ram[i_idx];
        end
    end

    // Data load port: captures RAM or MMIO on oe, otherwise holds
    always_ff @(posedge clk) begin
        if (!rst) begin
            d_mem_r_data <= '0;
        end else if (oe) begin
            d_mem_r_data <= mmio_hit ? mmio_rdata : ram[d_idx];
        end
    end

    // Console status word as seen by a load presented this cycle
    always_comb begin
        status_word                           = '0;
        status_word[ST_EMPTY_BIT]             = con_empty;
        status_word[ST_FULL_BIT]              = con_full;
        status_word[ST_OVF_BIT]               = overflow;
        status_word[ST_COUNT_LSB +: CNT_W]    = con_count;
    end

    // Next counter value: a write clears it instead of incrementing
    always_comb begin
        cycle_next = cycle_cnt + 32'd1;
        if (cyc_wr) begin
            cycle_next = '0;
        end
    end

    // MMIO read mux; CYCLE returns the count that is current once the
    // load data appears, so the returned value and the counter agree.
    always_comb begin
        mmio_rdata = '0;
        case (mmio_ofs)
            CON_STATUS_OFS: mmio_rdata = status_word;
            CYCLE_OFS:      mmio_rdata = cycle_next;
            default:        mmio_rdata = '0;
        endcase
    end

    // Free-running cycle counter, wraps naturally at 32 bits
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_next;
        end
    end

    // Sticky overflow: a dropped push outranks the clear from a status read
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (status_rd) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expected load/fetch
// words and console bytes into queues; a monitor pops and compares when the
// DUT presents data (one cycle after oe / fetch, or on a console handshake).
module tb_mem_responder;

    localparam logic [31:0] MB = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] i_mem_r_addr = '0;
    logic [31:0] i_mem_r_data;
    logic [31:0] d_mem_w_addr = '0;
    logic [31:0] d_mem_w_data = '0;
    logic [31:0] d_mem_we = '0;
    logic [31:0] d_mem_oe = '0;
    logic [31:0] d_mem_r_data;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] d_exp_q[$];
    logic [31:0] i_exp_q[$];
    logic [7:0]  con_exp_q[$];
    logic        i_chk  = 1'b0;
    logic        d_pend = 1'b0;
    logic        i_pend = 1'b0;

    mem_responder dut (
        .clk          (clk),
        .rst          (rst),
        .i_mem_r_addr (i_mem_r_addr),
        .i_mem_r_data (i_mem_r_data),
        .d_mem_w_addr (d_mem_w_addr),
        .d_mem_w_data (d_mem_w_data),
        .d_mem_we     (d_mem_we),
        .d_mem_oe     (d_mem_oe),
        .d_mem_r_data (d_mem_r_data),
        .con_data     (con_data),
        .con_valid    (con_valid),
        .con_ready    (con_ready)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Remember which outputs become due after this edge
    always @(posedge clk) begin
        d_pend <= d_mem_oe[0] & rst;
        i_pend <= i_chk & rst;
    end

    // Monitor: compare due outputs and console handshakes against the queues
    always @(negedge clk) begin
        if (d_pend) begin
            if (d_exp_q.size() == 0) check32("d_unexpected", d_mem_r_data, 32'hxxxx_xxxx);
            else check32("d_read", d_mem_r_data, d_exp_q.pop_front());
        end
        if (i_pend) begin
            if (i_exp_q.size() == 0) check32("i_unexpected", i_mem_r_data, 32'hxxxx_xxxx);
            else check32("i_fetch", i_mem_r_data, i_exp_q.pop_front());
        end
        if (con_valid && con_ready) begin
            if (con_exp_q.size() == 0) check32("con_unexpected", {24'h0, con_data}, 32'hxxxx_xxxx);
            else check32("con_byte", {24'h0, con_data}, {24'h0, con_exp_q.pop_front()});
        end
    end

    task automatic op(input logic w, input logic o, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] dexp, input logic ic, input logic [31:0] ia,
                      input logic [31:0] iexp);
        d_mem_we     = {31'b0, w};
        d_mem_oe     = {31'b0, o};
        d_mem_w_addr = a;
        d_mem_w_data = wd;
        i_mem_r_addr = ia;
        i_chk        = ic;
        if (o && rst) d_exp_q.push_back(dexp);
        if (ic && rst) i_exp_q.push_back(iexp);
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd);
        op(1'b1, 1'b0, a, wd, 32'h0, 1'b0, 32'h40, 32'h0);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] exp);
        op(1'b0, 1'b1, a, 32'h0, exp, 1'b0, 32'h40, 32'h0);
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0, 32'h40, 32'h0);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 20 && con_valid; k++) idle();
        check32({name, "_valid_low"}, {31'h0, con_valid}, 32'h0);
        check32({name, "_all_seen"}, con_exp_q.size(), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check32("rst_i_data", i_mem_r_data, 32'h0);
        check32("rst_d_data", d_mem_r_data, 32'h0);
        check32("rst_con_valid", {31'h0, con_valid}, 32'h0);
        check32("rst_con_data", {24'h0, con_data}, 32'h0);
        rst = 1'b1;

        // Store then load/fetch; read-first on simultaneous we+oe and fetch
        store(32'h40, 32'hDEAD_BEEF);
        op(1'b0, 1'b1, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b1, 32'h40, 32'hDEAD_BEEF);
        op(1'b1, 1'b1, 32'h40, 32'h1, 32'hDEAD_BEEF, 1'b1, 32'h40, 32'hDEAD_BEEF);
        op(1'b0, 1'b1, 32'h40, 32'h0, 32'h1, 1'b1, 32'h40, 32'h1);
        idle();
        check32("d_hold_oe_low", d_mem_r_data, 32'h1);

        // Aliasing, wrap, unmapped MMIO and MMIO isolation from RAM
        load(32'h0000_4040, 32'h1);
        load(32'h1234_0040, 32'h1);
        load(MB + 32'h0C, 32'h0);
        load(MB + 32'h00, 32'h0);
        store(32'h3F40, 32'hCAFE_0000);
        store(MB + 32'h40, 32'h11);
        op(1'b0, 1'b1, 32'h3F40, 32'h0, 32'hCAFE_0000, 1'b1, MB + 32'h40, 32'hCAFE_0000);
        store(32'h3FFC, 32'hA5A5_0001);
        load(32'h0000_FFFC, 32'hA5A5_0001);

        // Console overflow: 9 pushes into an 8-deep FIFO with the sink stalled
        con_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            store(MB, 32'h41 + i);
            if (i < 8) con_exp_q.push_back(8'(8'h41 + i));
        end
        load(MB + 32'h04, 32'h0000_0806);
        con_ready = 1'b1;
        drain("drain1");
        con_ready = 1'b0;
        load(MB + 32'h04, 32'h0000_0001);

        // Full FIFO with simultaneous pop and push keeps count at 8
        for (int i = 0; i < 8; i++) begin
            store(MB, 32'h50 + i);
            con_exp_q.push_back(8'(8'h50 + i));
        end
        con_ready = 1'b1;
        store(MB, 32'h5A);
        con_exp_q.push_back(8'h5A);
        con_ready = 1'b0;
        load(MB + 32'h04, 32'h0000_0802);
        con_ready = 1'b1;
        drain("drain2");
        con_ready = 1'b0;

        // Mid-transfer reset discards console bytes and a store in the reset cycle
        store(MB, 32'h61);
        store(MB, 32'h62);
        rst = 1'b0;
        con_exp_q.delete();
        store(32'h40, 32'h0000_0BAD);
        check32("rst2_d_data", d_mem_r_data, 32'h0);
        check32("rst2_i_data", i_mem_r_data, 32'h0);
        check32("rst2_con_valid", {31'h0, con_valid}, 32'h0);
        check32("rst2_con_data", {24'h0, con_data}, 32'h0);
        rst = 1'b1;

        // Counter is 0 after the reset edge, 10 after 10 idle edges; the read
        // shows the value reached at its own capture edge, i.e. 11.
        for (int i = 0; i < 10; i++) idle();
        load(MB + 32'h08, 32'd11);
        store(MB + 32'h08, 32'hFFFF_FFFF);
        load(MB + 32'h08, 32'd1);
        load(32'h40, 32'h1);
        load(MB + 32'h04, 32'h0000_0001);

        idle();
        idle();
        check32("d_queue_empty", d_exp_q.size(), 32'h0);
        check32("i_queue_empty", i_exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
